// File: rtl/fwd_hazard_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// The master drives the ID-stage fields and result buses; the slave returns the stall and forwarding controls.
interface fwd_hazard_if #(
   parameter int DW   = 8,
   parameter int RAW  = 5,
   parameter int CNTW = 16
);
   logic            id_valid;
   logic [RAW-1:0]  id_rs1;
   logic [RAW-1:0]  id_rs2;
   logic [RAW-1:0]  id_rd;
   logic            id_we;
   logic            id_is_load;
   logic            flush;
   logic [DW-1:0]   mem_result;
   logic [DW-1:0]   wb_result;
   logic            stall;
   logic [1:0]      sel1;
   logic [1:0]      sel2;
   logic [DW-1:0]   fwd_val1;
   logic [DW-1:0]   fwd_val2;
   logic [CNTW-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_we, id_is_load, flush,
      output mem_result, wb_result,
      input  stall, sel1, sel2, fwd_val1, fwd_val2, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_is_load, flush,
      input  mem_result, wb_result,
      output stall, sel1, sel2, fwd_val1, fwd_val2, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding source and load-use stall control for both ALU operands.
// Tracks destinations through EX/MEM/WB and selects the youngest producer for each EX source.
//
//   state | meaning
//   RUN   | normal issue; stall asserted combinationally on a load-use hazard
//   STALL | bubble cycle after a stall; the load has moved on, so return to RUN
module fwd_hazard_unit #(
   parameter int DW   = 8,
   parameter int RAW  = 5,
   parameter int CNTW = 16
) (
   input logic          clk,
   input logic          rst_n,
   fwd_hazard_if.slave  bus
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b10;
   localparam logic [1:0] SEL_WB  = 2'b11;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic            ex_valid;
   logic [RAW-1:0]  ex_rs1;
   logic [RAW-1:0]  ex_rs2;
   logic [RAW-1:0]  ex_rd;
   logic            ex_we;
   logic            ex_is_load;

   logic            mem_valid;
   logic [RAW-1:0]  mem_rd;
   logic            mem_we;
   logic            mem_is_load;

   logic            wb_valid;
   logic [RAW-1:0]  wb_rd;
   logic            wb_we;

   logic            hazard;
   logic            stall_int;
   logic [CNTW-1:0] stall_cnt;
   logic [1:0]      sel1, sel2;
   logic [DW-1:0]   fwd_val1, fwd_val2;

   // A load in EX cannot feed the instruction behind it until the load reaches WB.
   assign hazard = bus.id_valid && ex_valid && ex_is_load && ex_we && (ex_rd != '0)
                   && ((ex_rd == bus.id_rs1) || (ex_rd == bus.id_rs2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_int = 1'b0;
      case (state)
         RUN: begin
            if (hazard && !bus.flush) begin
               stall_int = 1'b1;
               state_nxt = STALL;
            end
         end
         STALL: state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_we       <= 1'b0;
         ex_is_load  <= 1'b0;
         mem_valid   <= 1'b0;
         mem_rd      <= '0;
         mem_we      <= 1'b0;
         mem_is_load <= 1'b0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_we       <= 1'b0;
      end else begin
         if (!stall_int && !bus.flush) begin
            ex_valid   <= bus.id_valid;
            ex_rs1     <= bus.id_rs1;
            ex_rs2     <= bus.id_rs2;
            ex_rd      <= bus.id_rd;
            ex_we      <= bus.id_we;
            ex_is_load <= bus.id_is_load;
         end else begin
            ex_valid   <= 1'b0;
         end
         mem_valid   <= ex_valid;
         mem_rd      <= ex_rd;
         mem_we      <= ex_we;
         mem_is_load <= ex_is_load;
         wb_valid    <= mem_valid;
         wb_rd       <= mem_rd;
         wb_we       <= mem_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall_int && (stall_cnt != {CNTW{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

   // MEM is checked first so the youngest producer wins; loads in MEM have no data yet.
   function automatic logic [1:0] pick_sel(input logic [RAW-1:0] rs);
      logic [1:0] s;
      s = SEL_RF;
      if (ex_valid && (rs != '0)) begin
         if (mem_valid && mem_we && !mem_is_load && (mem_rd == rs))
            s = SEL_MEM;
         else if (wb_valid && wb_we && (wb_rd == rs))
            s = SEL_WB;
      end
      return s;
   endfunction

   always_comb begin
      sel1     = pick_sel(ex_rs1);
      sel2     = pick_sel(ex_rs2);
      fwd_val1 = '0;
      fwd_val2 = '0;
      case (sel1)
         SEL_MEM: fwd_val1 = bus.mem_result;
         SEL_WB:  fwd_val1 = bus.wb_result;
         default: fwd_val1 = '0;
      endcase
      case (sel2)
         SEL_MEM: fwd_val2 = bus.mem_result;
         SEL_WB:  fwd_val2 = bus.wb_result;
         default: fwd_val2 = '0;
      endcase
   end

   assign bus.stall     = stall_int;
   assign bus.sel1      = sel1;
   assign bus.sel2      = sel2;
   assign bus.fwd_val1  = fwd_val1;
   assign bus.fwd_val2  = fwd_val2;
   assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use stall, flush, reset and counter saturation.
module tb_fwd_hazard_unit;
   localparam int DW   = 8;
   localparam int RAW  = 5;
   localparam int CNTW = 3;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   fwd_hazard_if #(.DW(DW), .RAW(RAW), .CNTW(CNTW)) bus ();

   fwd_hazard_unit #(.DW(DW), .RAW(RAW), .CNTW(CNTW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic v, input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                        input logic [RAW-1:0] rd, input logic we, input logic ld);
      bus.id_valid   = v;
      bus.id_rs1     = rs1;
      bus.id_rs2     = rs2;
      bus.id_rd      = rd;
      bus.id_we      = we;
      bus.id_is_load = ld;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drain;
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bus.flush = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.flush      = 1'b0;
      bus.mem_result = '0;
      bus.wb_result  = '0;
      issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      #2;
      check("rst_stall", 16'(bus.stall), 16'h0);
      check("rst_sel1", 16'(bus.sel1), 16'h0);
      check("rst_sel2", 16'(bus.sel2), 16'h0);
      check("rst_fwd1", 16'(bus.fwd_val1), 16'h0);
      check("rst_cnt", 16'(bus.stall_cnt), 16'h0);
      tick();
      rst_n = 1'b1;
      drain();

      // back-to-back ALU
      issue(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0);
      tick();
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bus.mem_result = 8'h5A;
      #1;
      check("b2b_sel1", 16'(bus.sel1), 16'h2);
      check("b2b_fwd1", 16'(bus.fwd_val1), 16'h5A);
      check("b2b_sel2", 16'(bus.sel2), 16'h0);
      check("b2b_fwd2", 16'(bus.fwd_val2), 16'h0);
      check("b2b_stall", 16'(bus.stall), 16'h0);
      drain();

      // distance two
      issue(1'b1, 5'd1, 5'd1, 5'd4, 1'b1, 1'b0);
      tick();
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      issue(1'b1, 5'd1, 5'd4, 5'd8, 1'b1, 1'b0);
      tick();
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bus.wb_result = 8'hC3;
      #1;
      check("d2_sel2", 16'(bus.sel2), 16'h3);
      check("d2_fwd2", 16'(bus.fwd_val2), 16'hC3);
      check("d2_sel1", 16'(bus.sel1), 16'h0);
      drain();

      // double hit, MEM wins
      issue(1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
      tick();
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bus.wb_result  = 8'h11;
      bus.mem_result = 8'h22;
      #1;
      check("dbl_sel1", 16'(bus.sel1), 16'h2);
      check("dbl_fwd1", 16'(bus.fwd_val1), 16'h22);
      check("dbl_sel2", 16'(bus.sel2), 16'h0);
      drain();

      // load-use
      issue(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd2, 5'd9, 5'd10, 1'b1, 1'b0);
      #1;
      check("lu_stall", 16'(bus.stall), 16'h1);
      check("lu_cnt0", 16'(bus.stall_cnt), 16'h0);
      tick();
      #1;
      check("lu_stall_clr", 16'(bus.stall), 16'h0);
      check("lu_cnt1", 16'(bus.stall_cnt), 16'h1);
      check("lu_bubble_sel1", 16'(bus.sel1), 16'h0);
      tick();
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bus.wb_result = 8'h77;
      #1;
      check("lu_sel1", 16'(bus.sel1), 16'h3);
      check("lu_fwd1", 16'(bus.fwd_val1), 16'h77);
      check("lu_cnt_hold", 16'(bus.stall_cnt), 16'h1);
      drain();

      // register zero
      issue(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
      tick();
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      check("x0_sel1", 16'(bus.sel1), 16'h0);
      check("x0_sel2", 16'(bus.sel2), 16'h0);
      drain();
      issue(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
      #1;
      check("x0_ld_stall", 16'(bus.stall), 16'h0);
      drain();

      // flush beats stall
      issue(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd2, 5'd9, 5'd10, 1'b1, 1'b0);
      bus.flush = 1'b1;
      #1;
      check("fl_stall", 16'(bus.stall), 16'h0);
      tick();
      bus.flush = 1'b0;
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      check("fl_ex_valid", 16'(dut.ex_valid), 16'h0);
      check("fl_cnt", 16'(bus.stall_cnt), 16'h1);
      drain();

      // reset while in STALL
      issue(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd2, 5'd9, 5'd10, 1'b1, 1'b0);
      tick();
      check("rs_cnt_pre", 16'(bus.stall_cnt), 16'h2);
      rst_n = 1'b0;
      #1;
      check("rs_stall", 16'(bus.stall), 16'h0);
      check("rs_sel1", 16'(bus.sel1), 16'h0);
      check("rs_fwd1", 16'(bus.fwd_val1), 16'h0);
      check("rs_cnt", 16'(bus.stall_cnt), 16'h0);
      #2;
      rst_n = 1'b1;
      tick();
      bus.wb_result = 8'h99;
      #1;
      check("rs_post_sel1", 16'(bus.sel1), 16'h0);
      check("rs_post_stall", 16'(bus.stall), 16'h0);
      drain();

      // stall counter saturates
      for (int i = 0; i < 8; i++) begin
         issue(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
         tick();
         issue(1'b1, 5'd2, 5'd9, 5'd10, 1'b1, 1'b0);
         tick();
         tick();
         issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         if (i == 6) check("sat_cnt7", 16'(bus.stall_cnt), 16'h7);
      end
      check("sat_cnt_hold", 16'(bus.stall_cnt), 16'h7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
